// File: rtl/switch_pkg.sv
// Shared constants and types for the switch input conditioning path.
// Imported by the debouncer top, its channels and the bench.
package switch_pkg;

  localparam int SW_WIDTH = 8;
  localparam int DEBOUNCE_CYCLES_50MHZ_1MS = 50000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  typedef enum logic {
    CH_IDLE     = 1'b0,
    CH_COUNTING = 1'b1
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One switch bit: two-flop synchronizer, persistence counter,
// and registered stable level with one-cycle rise/fall pulses.
module debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_1MS
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          stable_nxt;
  logic          rise_nxt;
  logic          fall_nxt;
  ch_state_e     state;

  // Bring the raw level into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Count while the synchronized level differs; accept on the last count.
  always_comb begin
    cnt_nxt    = '0;
    stable_nxt = stable;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    state      = (sync2 != stable) ? CH_COUNTING : CH_IDLE;
    unique case (state)
      CH_IDLE: begin
        cnt_nxt = '0;
      end
      CH_COUNTING: begin
        if (cnt == LAST) begin
          stable_nxt = sync2;
          rise_nxt   = sync2;
          fall_nxt   = ~sync2;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    endcase
  end

  // Counter, accepted level and edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
    end
  end

  assign accept = rise_nxt | fall_nxt;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the slide-switch vector feeding the switches PIO.
// Registers a summary change flag aligned with the edge pulses.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_1MS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .sw_raw(sw_raw[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .accept(accept[i])
    );
  end

  // Flag any acceptance in the same cycle the pulses appear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a 4-cycle debounce.
// Inputs change 1 ns after a rising edge; outputs sampled there too.
module tb_switch_debouncer;
  import switch_pkg::*;

  logic                clk;
  logic                reset;
  logic [SW_WIDTH-1:0] sw_raw;
  logic [SW_WIDTH-1:0] stable;
  logic [SW_WIDTH-1:0] rise;
  logic [SW_WIDTH-1:0] fall;
  logic                changed;

  int n_chk;
  int n_pass;

  switch_debouncer #(
    .WIDTH          (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .stable (stable),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, stable, rise, fall, changed};
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] s,
                                     input logic [7:0] r,
                                     input logic [7:0] f,
                                     input logic c);
    return {7'd0, s, r, f, c};
  endfunction

  logic [7:0] bounce [5];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    sw_raw = 8'hFF;
    bounce = '{8'h04, 8'h00, 8'h04, 8'h00, 8'h04};

    // 1: reset with switches high, then power-up rise
    repeat (3) tick();
    chk("rst_outs", outs(), mk(8'h00, 8'h00, 8'h00, 1'b0));
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("pwr_wait", outs(), mk(8'h00, 8'h00, 8'h00, 1'b0));
    end
    tick();
    chk("pwr_acc", outs(), mk(8'hFF, 8'hFF, 8'h00, 1'b1));
    tick();
    chk("pwr_pulse_end", outs(), mk(8'hFF, 8'h00, 8'h00, 1'b0));

    // return to zero
    sw_raw = 8'h00;
    repeat (5) tick();
    tick();
    chk("fall_all", outs(), mk(8'h00, 8'h00, 8'hFF, 1'b1));
    repeat (3) tick();

    // 2: 3-cycle glitch on bit 0
    sw_raw = 8'h01;
    repeat (3) tick();
    sw_raw = 8'h00;
    for (int j = 0; j < 10; j++) begin
      chk("glitch", outs(), mk(8'h00, 8'h00, 8'h00, 1'b0));
      tick();
    end

    // 3: bounce on bit 2 then settle high
    for (int j = 0; j < 4; j++) begin
      sw_raw = bounce[j];
      tick();
      chk("bounce", outs(), mk(8'h00, 8'h00, 8'h00, 1'b0));
    end
    sw_raw = bounce[4];
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("settle_wait", outs(), mk(8'h00, 8'h00, 8'h00, 1'b0));
    end
    tick();
    chk("settle_acc", outs(), mk(8'h04, 8'h04, 8'h00, 1'b1));
    tick();
    chk("settle_end", outs(), mk(8'h04, 8'h00, 8'h00, 1'b0));

    // 4: move to 0x08, then opposite edges to 0x20
    sw_raw = 8'h08;
    repeat (10) tick();
    chk("pre_opp", outs(), mk(8'h08, 8'h00, 8'h00, 1'b0));
    sw_raw = 8'h20;
    repeat (5) tick();
    chk("opp_wait", outs(), mk(8'h08, 8'h00, 8'h00, 1'b0));
    tick();
    chk("opp_acc", outs(), mk(8'h20, 8'h20, 8'h08, 1'b1));
    tick();
    chk("opp_end", outs(), mk(8'h20, 8'h00, 8'h00, 1'b0));

    // 5: reset on the third counting cycle
    sw_raw = 8'h21;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst", outs(), mk(8'h00, 8'h00, 8'h00, 1'b0));
    tick();
    chk("mid_rst_hold", outs(), mk(8'h00, 8'h00, 8'h00, 1'b0));
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("rel_wait", outs(), mk(8'h00, 8'h00, 8'h00, 1'b0));
    end
    tick();
    chk("rel_acc", outs(), mk(8'h21, 8'h21, 8'h00, 1'b1));
    tick();
    chk("rel_end", outs(), mk(8'h21, 8'h00, 8'h00, 1'b0));

    // 6: held level
    sw_raw = 8'h5A;
    repeat (5) tick();
    tick();
    chk("held_acc", outs(), mk(8'h5A, 8'h5A, 8'h21, 1'b1));
    for (int j = 0; j < 100; j++) begin
      tick();
      chk("held", outs(), mk(8'h5A, 8'h00, 8'h00, 1'b0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
